// File: rtl/slot_tracker_pkg.sv
// Shared width helpers and a one-hot decoder for the slot tracker.
package slot_tracker_pkg;

    // Widest slot count the one-hot helper supports.
    localparam int unsigned MAX_W = 1024;

    function automatic int unsigned idx_width(int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [MAX_W-1:0] onehot(int unsigned idx);
        return MAX_W'(1) << idx;
    endfunction

endpackage

// File: rtl/slot_tracker_if.sv
// Alloc/free handshake and status bundle of the slot tracker.
interface slot_tracker_if #(
    parameter int unsigned W = 32
);
    import slot_tracker_pkg::*;

    localparam int unsigned IW = idx_width(W);
    localparam int unsigned CW = cnt_width(W);

    logic          alloc_vld_i;
    logic          alloc_rdy_o;
    logic [IW-1:0] alloc_idx_o;
    logic          free_vld_i;
    logic [IW-1:0] free_idx_i;
    logic [W-1:0]  occ_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic          err_o;

    modport master (
        output alloc_vld_i, free_vld_i, free_idx_i,
        input  alloc_rdy_o, alloc_idx_o, occ_o, count_o, full_o, empty_o, err_o
    );

    modport slave (
        input  alloc_vld_i, free_vld_i, free_idx_i,
        output alloc_rdy_o, alloc_idx_o, occ_o, count_o, full_o, empty_o, err_o
    );

endinterface

// File: rtl/slot_tracker_search.sv
// Combinational circular first-zero search starting at start_i, wrapping upward.
module slot_tracker_search import slot_tracker_pkg::*; #(
    parameter  int unsigned W  = 32,
    localparam int unsigned IW = idx_width(W)
) (
    input  logic [W-1:0]  vec_i,
    input  logic [IW-1:0] start_i,
    output logic [W-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [W-1:0] rot;
    logic [W-1:0] pri;

    always_comb begin
        rot = '0;
        for (int i = 0; i < W; i++) begin
            rot[i] = vec_i[IW'(i + int'(start_i))];
        end
        // Lowest zero of rot: ~rot & (rot + 1).
        pri = ~rot & (rot + W'(1));
        any_o = ~&rot;
    end

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < W; i++) begin
            onehot_o[i] = pri[IW'(i + int'(W) - int'(start_i))];
        end
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot_o[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/slot_tracker.sv
// Slot occupancy bitmap with round-robin allocation and strobe-driven release.
// Optional SLOT_TRACKER_FREE_BYPASS_EN lets a slot freed this cycle be granted this cycle.
module slot_tracker import slot_tracker_pkg::*; #(
    parameter int unsigned W = 32
) (
    input logic           clk,
    input logic           rst_n,
    slot_tracker_if.slave bus
);

    localparam int unsigned IW = idx_width(W);
    localparam int unsigned CW = cnt_width(W);

    typedef logic [IW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    logic [W-1:0] occ_q, occ_d;
    idx_t         ptr_q, ptr_d;
    cnt_t         count_q, count_d;
    logic         err_q, err_d;

    logic [W-1:0] search_vec;
    logic [W-1:0] grant_oh;
    idx_t         grant_idx;
    logic         grant_any;
    logic         free_hit;
    logic         fire;
    logic         free_ok;

    assign free_hit = |(onehot(32'(bus.free_idx_i)) & MAX_W'(occ_q));

    always_comb begin
        search_vec = occ_q;
`ifdef SLOT_TRACKER_FREE_BYPASS_EN
        if (bus.free_vld_i && free_hit) search_vec[bus.free_idx_i] = 1'b0;
`endif
    end

    slot_tracker_search #(
        .W (W)
    ) u_search (
        .vec_i    (search_vec),
        .start_i  (ptr_q),
        .onehot_o (grant_oh),
        .idx_o    (grant_idx),
        .any_o    (grant_any)
    );

    assign fire    = bus.alloc_vld_i & grant_any;
    assign free_ok = bus.free_vld_i & free_hit;

    always_comb begin
        occ_d   = occ_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q | (bus.free_vld_i & ~free_hit);
        // Clear before set so a bypassed same-index alloc+free leaves the bit set.
        if (free_ok) occ_d[bus.free_idx_i] = 1'b0;
        if (fire) begin
            occ_d = occ_d | grant_oh;
            ptr_d = grant_idx + idx_t'(1);
        end
        if (fire && !free_ok) begin
            count_d = count_q + cnt_t'(1);
        end else if (!fire && free_ok) begin
            count_d = count_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (int'(count_q) == $countones(occ_q))
                else $error("slot_tracker: count does not match occupancy");
        end
    end

    assign bus.alloc_rdy_o = grant_any;
    assign bus.alloc_idx_o = grant_idx;
    assign bus.occ_o       = occ_q;
    assign bus.count_o     = count_q;
    assign bus.full_o      = (count_q == cnt_t'(W));
    assign bus.empty_o     = (count_q == '0);
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_slot_tracker.sv
// Directed bench for slot_tracker with W=8; honours SLOT_TRACKER_FREE_BYPASS_EN.
module tb_slot_tracker;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    int unsigned n_checks;
    int unsigned n_pass;

    slot_tracker_if #(.W(W)) bus ();

    slot_tracker #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        bus.free_idx_i  = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        bus.free_idx_i  = '0;
        step();
        do_reset();

        check("rst_rdy",   32'(bus.alloc_rdy_o), 32'd1);
        check("rst_idx",   32'(bus.alloc_idx_o), 32'd0);
        check("rst_full",  32'(bus.full_o),      32'd0);
        check("rst_empty", 32'(bus.empty_o),     32'd1);
        check("rst_err",   32'(bus.err_o),       32'd0);
        check("rst_count", 32'(bus.count_o),     32'd0);
        check("rst_occ",   32'(bus.occ_o),       32'h00);

        // Fill in order.
        bus.alloc_vld_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fill_idx%0d", i), 32'(bus.alloc_idx_o), 32'(i));
            check($sformatf("fill_rdy%0d", i), 32'(bus.alloc_rdy_o), 32'd1);
            step();
        end
        bus.alloc_vld_i = 1'b0;
        check("full_full",  32'(bus.full_o),      32'd1);
        check("full_rdy",   32'(bus.alloc_rdy_o), 32'd0);
        check("full_count", 32'(bus.count_o),     32'd8);
        check("full_occ",   32'(bus.occ_o),       32'hFF);

        // Free 3 from full, then reallocate it.
        bus.free_vld_i = 1'b1;
        bus.free_idx_i = 3'd3;
        step();
        bus.free_vld_i = 1'b0;
        check("f3_occ",   32'(bus.occ_o),       32'hF7);
        check("f3_count", 32'(bus.count_o),     32'd7);
        check("f3_rdy",   32'(bus.alloc_rdy_o), 32'd1);
        check("f3_idx",   32'(bus.alloc_idx_o), 32'd3);
        bus.alloc_vld_i = 1'b1;
        step();
        bus.alloc_vld_i = 1'b0;
        check("f3_refull", 32'(bus.full_o), 32'd1);
        check("f3_reocc",  32'(bus.occ_o),  32'hFF);

        // Wrap-around from ptr=5 over occ=0001_0110.
        do_reset();
        bus.alloc_vld_i = 1'b1;
        repeat (5) step();
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b1;
        bus.free_idx_i  = 3'd0;
        step();
        bus.free_idx_i  = 3'd3;
        step();
        bus.free_vld_i  = 1'b0;
        check("wrap_setup_occ", 32'(bus.occ_o),   32'h16);
        check("wrap_setup_cnt", 32'(bus.count_o), 32'd3);
        bus.alloc_vld_i = 1'b1;
        check("wrap_g5", 32'(bus.alloc_idx_o), 32'd5);
        step();
        check("wrap_g6", 32'(bus.alloc_idx_o), 32'd6);
        step();
        check("wrap_g7", 32'(bus.alloc_idx_o), 32'd7);
        step();
        check("wrap_g0", 32'(bus.alloc_idx_o), 32'd0);
        step();
        bus.alloc_vld_i = 1'b0;
        check("wrap_occ",   32'(bus.occ_o),   32'hF7);
        check("wrap_count", 32'(bus.count_o), 32'd7);

        // Simultaneous alloc (grant 2) and free 0.
        do_reset();
        bus.alloc_vld_i = 1'b1;
        repeat (2) step();
        check("sim_idx", 32'(bus.alloc_idx_o), 32'd2);
        bus.free_vld_i = 1'b1;
        bus.free_idx_i = 3'd0;
        step();
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        check("sim_occ",   32'(bus.occ_o),   32'h06);
        check("sim_count", 32'(bus.count_o), 32'd2);

        // Double free of slot 4 sets sticky error.
        bus.free_vld_i = 1'b1;
        bus.free_idx_i = 3'd4;
        step();
        bus.free_vld_i = 1'b0;
        check("dbl_err",   32'(bus.err_o),   32'd1);
        check("dbl_occ",   32'(bus.occ_o),   32'h06);
        check("dbl_count", 32'(bus.count_o), 32'd2);
        step();
        check("dbl_sticky", 32'(bus.err_o), 32'd1);
        do_reset();
        check("dbl_rst_err",   32'(bus.err_o),   32'd0);
        check("dbl_rst_occ",   32'(bus.occ_o),   32'h00);
        check("dbl_rst_empty", 32'(bus.empty_o), 32'd1);

        // Full, free 6 with alloc in the same cycle.
        bus.alloc_vld_i = 1'b1;
        repeat (8) step();
        check("byp_pre_full", 32'(bus.full_o), 32'd1);
        bus.free_vld_i = 1'b1;
        bus.free_idx_i = 3'd6;
        #1;
`ifdef SLOT_TRACKER_FREE_BYPASS_EN
        check("byp_rdy", 32'(bus.alloc_rdy_o), 32'd1);
        check("byp_idx", 32'(bus.alloc_idx_o), 32'd6);
        step();
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        check("byp_full",  32'(bus.full_o),  32'd1);
        check("byp_count", 32'(bus.count_o), 32'd8);
        check("byp_occ",   32'(bus.occ_o),   32'hFF);
`else
        check("nobyp_rdy", 32'(bus.alloc_rdy_o), 32'd0);
        step();
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        check("nobyp_occ",   32'(bus.occ_o),   32'hBF);
        check("nobyp_count", 32'(bus.count_o), 32'd7);
`endif
        check("byp_err", 32'(bus.err_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
